ysyx_24070017_mem_arbiter: RTL and testbench
============================================

Name: ysyx_24070017_mem_arbiter

Overview:
Shares the CPU's single memory port between the instruction fetch unit (requester 0, IFU) and the load/store unit (requester 1, LSU). Accepts one request at a time over a valid/ready handshake, forwards it to memory, and routes the response back to the requester that owns the transaction. Arbitration is round-robin. A watchdog flags memory transactions that stall.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width (ysyx_24070017_WORD_LENGTH).
TIMEOUT, 1024, maximum cycles a transaction may stay outstanding; 0 disables the watchdog.

Ports:
clk  in  1  clock; every register updates on the rising edge.
rst  in  1  reset; synchronous, active-high.
ifu_req_valid / lsu_req_valid  in  1  request valid, one per requester.
ifu_req_ready / lsu_req_ready  out  1  request accepted this cycle.
ifu_addr / lsu_addr  in  ADDR_W  request address.
lsu_wen  in  1  1 = write, 0 = read. The IFU always issues reads.
lsu_wdata  in  DATA_W  write data.
lsu_wstrb  in  4  byte enables for a write.
ifu_resp_valid / lsu_resp_valid  out  1  response valid.
ifu_resp_ready / lsu_resp_ready  in  1  requester accepts the response.
ifu_rdata / lsu_rdata  out  DATA_W  read data; only meaningful while the matching resp_valid is high.
mem_req_valid  out  1  downstream request valid.
mem_req_ready  in  1  downstream request accepted.
mem_addr  out  ADDR_W  downstream address.
mem_wen  out  1  downstream write enable.
mem_wdata  out  DATA_W  downstream write data.
mem_wstrb  out  4  downstream byte enables.
mem_resp_valid  in  1  downstream response valid.
mem_resp_ready  out  1  arbiter accepts the downstream response.
mem_rdata  in  DATA_W  downstream read data.
owner  out  1  requester owning the current transaction (0 = IFU, 1 = LSU).
timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, owner = 0, last_grant = 0 (the LSU wins the first tie).
  - Timeout counter = 0; timeout_err = 0.
  - All valid and ready outputs = 0; latched request fields = 0.
  - Reset mid-transaction abandons it: no response is forwarded, and any later mem_resp_valid is ignored (mem_resp_ready = 0 in IDLE).
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - grant = the single valid requester. If both are valid, grant = !last_grant.
  - The granted requester's req_ready = 1, combinationally, in the same cycle. The other requester's req_ready = 0.
  - On acceptance, latch addr/wen/wdata/wstrb (IFU: wen = 0, wstrb = 0, wdata = 0), set owner = grant, go to REQ.
  - No valid requester: stay in IDLE.
- REQ:
  - mem_req_valid = 1, driven from the latched fields; the fields are stable until mem_req_ready.
  - Both upstream req_ready = 0.
  - On mem_req_ready, go to RESP. The request appears downstream exactly 1 cycle after upstream acceptance.
- RESP:
  - Owner's resp_valid = mem_resp_valid; owner's rdata = mem_rdata; mem_resp_ready = owner's resp_ready. All three are combinational pass-through.
  - The non-owner's resp_valid = 0.
  - When mem_resp_valid and resp_ready are both high: last_grant = owner, go to IDLE.
  - Minimum transaction time: 3 cycles (accept, REQ, RESP). Back-to-back issue has one IDLE cycle between transactions.
- Write responses: a response is still required (data ignored). The LSU must accept it.
- Watchdog:
  - The counter is cleared on entry to REQ and increments every cycle in REQ or RESP, saturating at TIMEOUT.
  - When it reaches TIMEOUT (TIMEOUT != 0), timeout_err is set and held until reset. The transaction keeps waiting; nothing is aborted.
- Only one transaction is outstanding at a time. A requester's valid may drop before acceptance; no grant is made if it does.

Decomposition:
- Shared package/header (alongside the existing ysyx_24070017_ defines):
  - FSM state encoding (IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2).
  - Requester ID constants (ID_IFU = 0, ID_LSU = 1).
  - The WSTRB width constant.
- One sub-module: ysyx_24070017_rr_pick2, a 2-way round-robin grant (inputs: valid[1:0], last_grant; output: grant, any). The latch registers use the existing ysyx_24070017_Reg.

Test Plan:
- Reset, then IFU read 0x80000000; memory has 0-cycle ready and returns 0x00100073 one cycle later → ifu_req_ready at cycle 0, mem_req_valid at cycle 1, ifu_resp_valid with ifu_rdata = 0x00100073 at cycle 2, lsu_resp_valid stays 0.
- Both requesters valid from reset → LSU granted first (owner = 1). The IFU is granted on the next IDLE, and the two then alternate for 4 transactions: 1, 0, 1, 0.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wstrb 4'b0011 → mem_wen = 1 and the fields are held unchanged while mem_req_ready is held low for 5 cycles. The transaction completes on the response.
- Response back-pressure: lsu_resp_ready = 0 for 3 cycles while mem_resp_valid = 1 → mem_resp_ready = 0 for those cycles, no state change, and the handshake completes on the 4th cycle.
- TIMEOUT = 8, memory never responds → timeout_err rises exactly 8 cycles after entry to REQ. It stays high after a late response completes the transaction, and clears only on rst.
- Assert rst during RESP, then pulse mem_resp_valid → neither requester sees resp_valid, state = IDLE, and a new IFU request is accepted the cycle after reset deasserts.

Source files
------------

// File: rtl/ysyx_24070017_mem_arbiter_pkg.sv
// Shared constants for the IFU/LSU memory arbiter: FSM encoding, requester IDs, widths.
package ysyx_24070017_mem_arbiter_pkg;
    localparam int ysyx_24070017_WORD_LENGTH = 32;
    localparam int WSTRB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic ID_IFU = 1'b0;
    localparam logic ID_LSU = 1'b1;
endpackage

// File: rtl/ysyx_24070017_Reg.sv
// Generic enable register with synchronous active-high reset.
module ysyx_24070017_Reg #(
    parameter int          WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);
    always_ff @(posedge clk) begin
        if (rst)      dout <= RESET_VAL;
        else if (wen) dout <= din;
    end
endmodule

// File: rtl/ysyx_24070017_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is granted.
module ysyx_24070017_rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);
    assign any   = |valid;
    assign grant = (&valid) ? ~last_grant : valid[1];
endmodule

// File: rtl/ysyx_24070017_mem_arbiter.sv
// Shares one memory port between IFU (id 0) and LSU (id 1); one transaction in flight,
// round-robin grant, sticky watchdog on stalled transactions.
module ysyx_24070017_mem_arbiter
    import ysyx_24070017_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = ysyx_24070017_WORD_LENGTH,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [ADDR_W-1:0]  ifu_addr,
    output logic               ifu_resp_valid,
    input  logic               ifu_resp_ready,
    output logic [DATA_W-1:0]  ifu_rdata,
    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [ADDR_W-1:0]  lsu_addr,
    input  logic               lsu_wen,
    input  logic [DATA_W-1:0]  lsu_wdata,
    input  logic [WSTRB_W-1:0] lsu_wstrb,
    output logic               lsu_resp_valid,
    input  logic               lsu_resp_ready,
    output logic [DATA_W-1:0]  lsu_rdata,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wen,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [WSTRB_W-1:0] mem_wstrb,
    input  logic               mem_resp_valid,
    output logic               mem_resp_ready,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               owner,
    output logic               timeout_err
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);

    logic [1:0]         state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  addr_d, addr_q;
    logic               wen_d, wen_q;
    logic [DATA_W-1:0]  wdata_d, wdata_q;
    logic [WSTRB_W-1:0] wstrb_d, wstrb_q;

    logic grant, any, accept, in_req, in_resp, owner_rready, done;

    ysyx_24070017_rr_pick2 u_pick (
        .valid      ({lsu_req_valid, ifu_req_valid}),
        .last_grant (last_q),
        .grant      (grant),
        .any        (any)
    );

    // A reset cycle never accepts or forwards anything, whatever state it interrupts.
    assign accept       = (state_q == ST_IDLE) && any && !rst;
    assign in_req       = (state_q == ST_REQ) && !rst;
    assign in_resp      = (state_q == ST_RESP) && !rst;
    assign owner_rready = (owner_q == ID_LSU) ? lsu_resp_ready : ifu_resp_ready;
    assign done         = in_resp && mem_resp_valid && owner_rready;

    assign ifu_req_ready  = accept && (grant == ID_IFU);
    assign lsu_req_ready  = accept && (grant == ID_LSU);
    assign mem_req_valid  = in_req;
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wstrb      = wstrb_q;
    assign mem_resp_ready = in_resp && owner_rready;
    assign ifu_resp_valid = in_resp && (owner_q == ID_IFU) && mem_resp_valid;
    assign lsu_resp_valid = in_resp && (owner_q == ID_LSU) && mem_resp_valid;
    assign ifu_rdata      = mem_rdata;
    assign lsu_rdata      = mem_rdata;
    assign owner          = owner_q;
    assign timeout_err    = err_q;

    always_comb begin
        addr_d  = (grant == ID_LSU) ? lsu_addr : ifu_addr;
        wen_d   = (grant == ID_LSU) && lsu_wen;
        wdata_d = (grant == ID_LSU) ? lsu_wdata : '0;
        wstrb_d = (grant == ID_LSU) ? lsu_wstrb : '0;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_REQ;
                owner_d = grant;
            end
            ST_REQ:  if (mem_req_ready) state_d = ST_RESP;
            ST_RESP: if (done) begin
                state_d = ST_IDLE;
                last_d  = owner_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter measures cycles spent in REQ/RESP since acceptance, saturating at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = '0;
        else if ((in_req || in_resp) && cnt_q != TMAX)
            cnt_d = cnt_q + 1'b1;
        err_d = err_q || ((TIMEOUT != 0) && (in_req || in_resp) && cnt_d == TMAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= ID_IFU;
            last_q  <= ID_IFU;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    ysyx_24070017_Reg #(.WIDTH(ADDR_W))  u_addr  (.clk(clk), .rst(rst), .din(addr_d),  .dout(addr_q),  .wen(accept));
    ysyx_24070017_Reg #(.WIDTH(1))       u_wen   (.clk(clk), .rst(rst), .din(wen_d),   .dout(wen_q),   .wen(accept));
    ysyx_24070017_Reg #(.WIDTH(DATA_W))  u_wdata (.clk(clk), .rst(rst), .din(wdata_d), .dout(wdata_q), .wen(accept));
    ysyx_24070017_Reg #(.WIDTH(WSTRB_W)) u_wstrb (.clk(clk), .rst(rst), .din(wstrb_d), .dout(wstrb_q), .wen(accept));
endmodule

// File: tb/tb_ysyx_24070017_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized transactions against a
// transaction-level model of grant order, latched fields, response routing and watchdog.
module tb_ysyx_24070017_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_ready, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        owner, timeout_err;

    int errs = 0;
    int checks = 0;
    bit last_grant;
    bit err_sticky;

    always #5 clk = ~clk;

    ysyx_24070017_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
        .owner(owner), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wstrb = 0;
        lsu_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        last_grant = 0;
        err_sticky = 0;
    endtask

    // One full transaction from IDLE: d cycles of mem_req_ready low, r cycles before the
    // memory responds, b cycles of requester back-pressure on the response.
    task automatic do_txn(input bit iv, input bit lv, input int d, input int r, input int b,
                          input logic [31:0] ia, input logic [31:0] la, input bit lw,
                          input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd);
        bit g;
        logic [31:0] ea, ewd;
        logic [3:0] ews;
        logic ew;
        int len;
        g   = (iv && lv) ? !last_grant : lv;
        ea  = g ? la : ia;
        ew  = g && lw;
        ewd = g ? wd : 32'h0;
        ews = g ? ws : 4'h0;

        ifu_req_valid = iv; lsu_req_valid = lv; ifu_addr = ia; lsu_addr = la;
        lsu_wen = lw; lsu_wdata = wd; lsu_wstrb = ws; mem_req_ready = 0;
        #1;
        check("ifu_req_ready", ifu_req_ready, iv && !g);
        check("lsu_req_ready", lsu_req_ready, lv && g);
        check("idle_mem_req_valid", mem_req_valid, 0);
        @(negedge clk);
        ifu_req_valid = 0; lsu_req_valid = 0;
        ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wstrb = 4'($urandom);
        for (int i = 0; i <= d; i++) begin
            mem_req_ready = (i == d);
            #1;
            check("mem_req_valid", mem_req_valid, 1);
            check("mem_addr", mem_addr, ea);
            check("mem_wen", mem_wen, ew);
            check("mem_wdata", mem_wdata, ewd);
            check("mem_wstrb", mem_wstrb, ews);
            check("owner", owner, g);
            check("req_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
            @(negedge clk);
        end
        mem_req_ready = 0;
        for (int i = 0; i < r; i++) begin
            ifu_resp_ready = 1; lsu_resp_ready = 1;
            #1;
            check("resp_wait_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
            check("resp_wait_mreq", mem_req_valid, 0);
            @(negedge clk);
        end
        for (int i = 0; i <= b; i++) begin
            mem_resp_valid = 1; mem_rdata = rd;
            ifu_resp_ready = g ? 1'b1 : (i == b);
            lsu_resp_ready = g ? (i == b) : 1'b1;
            #1;
            check("ifu_resp_valid", ifu_resp_valid, !g);
            check("lsu_resp_valid", lsu_resp_valid, g);
            check("owner_rdata", g ? lsu_rdata : ifu_rdata, rd);
            check("mem_resp_ready", mem_resp_ready, i == b);
            @(negedge clk);
        end
        mem_resp_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
        len = d + 1 + r + b + 1;
        if (len >= 8) err_sticky = 1;
        last_grant = g;
        #1;
        check("done_mem_req_valid", mem_req_valid, 0);
        check("done_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
        check("timeout_err", timeout_err, err_sticky);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        #1;
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_req_ready", {ifu_req_ready, lsu_req_ready}, 0);
        check("rst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
        check("rst_mem_resp_ready", mem_resp_ready, 0);
        check("rst_owner", owner, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_fields", {mem_addr, mem_wen, mem_wstrb}, 0);

        // IFU fetch with zero-latency memory
        do_txn(1, 0, 0, 0, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 32'h0010_0073);

        // Both valid from reset: LSU first, then alternation
        do_reset();
        for (int k = 0; k < 4; k++)
            do_txn(1, 1, 0, 0, 0, 32'h8000_0100 + k, 32'h8000_2000 + k, k[0], $urandom, 4'hF, $urandom);

        // LSU write held downstream for 5 cycles
        do_txn(0, 1, 5, 0, 0, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 32'h0);
        // Response back-pressure for 3 cycles
        do_txn(0, 1, 0, 0, 3, 32'h0, 32'h8000_1004, 0, 32'h0, 4'h0, 32'h1234_5678);

        for (int k = 0; k < 40; k++) begin
            int sel, d, r, b;
            sel = $urandom_range(1, 3);
            d = $urandom_range(0, 2);
            r = $urandom_range(0, 2);
            b = $urandom_range(0, 5 - d - r);
            do_txn(sel[0], sel[1], d, r, b, $urandom, $urandom, 1'($urandom), $urandom,
                   4'($urandom), $urandom);
        end

        // Watchdog: memory accepts but never responds
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0040; mem_req_ready = 1;
        #1;
        check("wd_accept", ifu_req_ready, 1);
        @(negedge clk);
        ifu_req_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) mem_req_ready = 0;
            #1;
            check("wd_err_early", timeout_err, 0);
            @(negedge clk);
        end
        #1;
        check("wd_err_rise", timeout_err, 1);
        @(negedge clk);
        @(negedge clk);
        mem_resp_valid = 1; mem_rdata = 32'hCAFE_0001; ifu_resp_ready = 1;
        #1;
        check("wd_late_resp", ifu_resp_valid, 1);
        @(negedge clk);
        mem_resp_valid = 0; ifu_resp_ready = 0;
        #1;
        check("wd_err_held", timeout_err, 1);
        check("wd_idle", mem_req_valid, 0);
        do_reset();
        #1;
        check("wd_err_cleared", timeout_err, 0);

        // Reset during RESP abandons the transaction
        ifu_req_valid = 1; ifu_addr = 32'h8000_0080; mem_req_ready = 1;
        @(negedge clk);
        ifu_req_valid = 0;
        @(negedge clk);
        mem_req_ready = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        mem_resp_valid = 1; mem_rdata = 32'h5555_AAAA;
        ifu_resp_ready = 1; lsu_resp_ready = 1;
        ifu_req_valid = 1; ifu_addr = 32'h8000_00C0;
        #1;
        check("abort_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
        check("abort_mem_resp_ready", mem_resp_ready, 0);
        check("abort_new_accept", ifu_req_ready, 1);
        @(negedge clk);
        ifu_req_valid = 0; mem_resp_valid = 0;
        #1;
        check("abort_new_req", mem_req_valid, 1);
        check("abort_new_addr", mem_addr, 32'h8000_00C0);
        check("abort_new_owner", owner, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
